// File: rtl/sraml_arbiter.sv
// Two-to-one round-robin arbiter merging the inst and data SRAM-like masters
// onto one SRAM-like slave port with at most one transaction in flight.
module sraml_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   owner_r;
  logic   owner_nxt_s;
  logic   last_r;
  logic   last_nxt_s;
  logic   owner_req_s;

  assign owner_req_s = owner_r ? data_req : inst_req;

  // State, current owner and round-robin history registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Grant selection and transaction sequencing.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        // Under contention the master that did not go last wins.
        if (inst_req && data_req) begin
          owner_nxt_s = ~last_r;
          state_nxt_s = ST_ADDR;
        end else if (data_req) begin
          owner_nxt_s = 1'b1;
          state_nxt_s = ST_ADDR;
        end else if (inst_req) begin
          owner_nxt_s = 1'b0;
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (!owner_req_s) begin
          last_nxt_s  = owner_r;
          state_nxt_s = ST_IDLE;
        end else if (s_addr_ok) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (s_data_ok) begin
          last_nxt_s  = owner_r;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Slave-side forwarding and owner-only handshake return, no added latency.
  always_comb begin
    s_wr         = owner_r ? data_wr    : inst_wr;
    s_size       = owner_r ? data_size  : inst_size;
    s_addr       = owner_r ? data_addr  : inst_addr;
    s_wdata      = owner_r ? data_wdata : inst_wdata;
    s_req        = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_r)
      ST_ADDR: begin
        s_req        = owner_req_s;
        inst_addr_ok = ~owner_r & owner_req_s & s_addr_ok;
        data_addr_ok =  owner_r & owner_req_s & s_addr_ok;
      end
      ST_DATA: begin
        inst_data_ok = ~owner_r & s_data_ok;
        data_data_ok =  owner_r & s_data_ok;
      end
      default: begin
        s_req = 1'b0;
      end
    endcase
  end

  assign inst_rdata = s_rdata;
  assign data_rdata = s_rdata;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sraml_arbiter.sv
// Scoreboard bench for sraml_arbiter: a transaction-level model predicts grants
// and read returns; a negedge monitor pops and compares on every DUT handshake.
module tb_sraml_arbiter;
  logic        clk, resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok, busy;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata;

  sraml_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
  typedef struct packed { logic own; req_t r; } gnt_t;
  typedef struct packed { logic own; logic [31:0] d; } rd_t;

  req_t preq [2];
  logic [1:0] pend;
  gnt_t gq[$];
  rd_t  rq[$];
  logic obs[$];
  int   checks, errors;

  // Transaction model: 0 free, 1 request outstanding, 2 awaiting completion.
  int   m_phase, acnt, dcnt, addr_wait, data_wait, reissue_left;
  logic m_win, m_last;
  logic stray_en, auto_en, force_dok, rdata_fix_en;
  logic [31:0] rdata_fix;

  logic        sn_busy, sn_sreq, sn_swr, sn_iaok, sn_daok, sn_idok, sn_ddok;
  logic [1:0]  sn_ssize;
  logic [31:0] sn_saddr, sn_swdata, sn_irdata;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input int m, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    pend[m] = 1'b1;
    preq[m] = '{wr: wr, size: size, addr: addr, wdata: wdata};
  endtask

  task automatic model_reset();
    m_phase = 0; m_last = 1'b0; m_win = 1'b0; pend = 2'b00;
    reissue_left = 0; acnt = 0; dcnt = 0;
    gq.delete(); rq.delete();
  endtask

  task automatic drive_masters();
    inst_req = pend[0]; inst_wr = preq[0].wr; inst_size = preq[0].size;
    inst_addr = preq[0].addr; inst_wdata = preq[0].wdata;
    data_req = pend[1]; data_wr = preq[1].wr; data_size = preq[1].size;
    data_addr = preq[1].addr; data_wdata = preq[1].wdata;
  endtask

  task automatic tick();
    if (auto_en)
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 2) == 0)
          issue(m, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom, $urandom);
    drive_masters();
    s_addr_ok = 1'b0;
    s_data_ok = force_dok;
    s_rdata   = $urandom;
    case (m_phase)
      1: s_addr_ok = (acnt == 0);
      2: begin
        s_data_ok = (dcnt == 0);
        if (rdata_fix_en) s_rdata = rdata_fix;
      end
      default: ;
    endcase
    if (stray_en && $urandom_range(0, 7) == 0 && m_phase != 1) s_addr_ok = 1'b1;
    if (stray_en && $urandom_range(0, 7) == 0 && m_phase != 2) s_data_ok = 1'b1;
    #2;
    sn_busy = busy; sn_sreq = s_req; sn_swr = s_wr; sn_ssize = s_size; sn_saddr = s_addr;
    sn_swdata = s_wdata; sn_iaok = inst_addr_ok; sn_daok = data_addr_ok;
    sn_idok = inst_data_ok; sn_ddok = data_data_ok; sn_irdata = inst_rdata;
    case (m_phase)
      0: if (pend != 2'b00) begin
        m_win = (pend == 2'b11) ? ~m_last : pend[1];
        gq.push_back('{own: m_win, r: preq[m_win]});
        acnt = (addr_wait < 0) ? int'($urandom_range(0, 2)) : addr_wait;
        m_phase = 1;
      end
      1: if (!pend[m_win]) begin
        void'(gq.pop_back());
        m_last = m_win;
        m_phase = 0;
      end else if (s_addr_ok) begin
        pend[m_win] = 1'b0;
        dcnt = (data_wait < 0) ? int'($urandom_range(0, 2)) : data_wait;
        m_phase = 2;
      end else begin
        acnt--;
      end
      2: if (s_data_ok) begin
        rq.push_back('{own: m_win, d: s_rdata});
        m_last = m_win;
        m_phase = 0;
        if (reissue_left > 0) begin
          reissue_left--;
          issue(int'(m_win), 1'b0, 2'd2, $urandom, $urandom);
        end
      end else begin
        dcnt--;
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((m_phase != 0 || pend != 2'b00) && n < 200) begin
      tick();
      n++;
    end
    chk(name, (m_phase == 0 && pend == 2'b00), 1);
  endtask

  task automatic check_order(input string name, input logic [5:0] exp, input int n);
    chk({name, "_len"}, obs.size(), n);
    for (int i = 0; i < n; i++)
      if (i < obs.size()) chk(name, obs[i], exp[i]);
  endtask

  task automatic do_reset(input logic check_vals);
    resetn = 1'b0;
    model_reset();
    drive_masters();
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h5A5A_A5A5;
    #1;
    if (check_vals) begin
      chk("rst_busy", busy, 0);
      chk("rst_sreq", s_req, 0);
      chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
      chk("rst_rdata", {inst_rdata, data_rdata}, {32'h5A5A_A5A5, 32'h5A5A_A5A5});
    end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Scoreboard monitor: every DUT handshake must match the oldest prediction.
  always @(negedge clk) begin : mon
    gnt_t g;
    rd_t  r;
    if (resetn) begin
      if (inst_addr_ok || data_addr_ok) begin
        chk("addr_ok_onehot", {inst_addr_ok, data_addr_ok}, {~data_addr_ok, data_addr_ok});
        chk("addr_ok_expected", gq.size() != 0, 1);
        if (gq.size() != 0) begin
          g = gq.pop_front();
          chk("grant", {data_addr_ok, s_wr, s_size, s_addr, s_wdata}, g);
          chk("grant_sreq", s_req, 1);
        end
        obs.push_back(data_addr_ok);
      end
      if (inst_data_ok || data_data_ok) begin
        chk("data_ok_expected", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          r = rq.pop_front();
          chk("rdata", {data_data_ok & ~inst_data_ok, data_data_ok ? data_rdata : inst_rdata}, r);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic found;
    checks = 0; errors = 0;
    addr_wait = -1; data_wait = -1;
    stray_en = 1'b0; auto_en = 1'b0; force_dok = 1'b0; rdata_fix_en = 1'b0; rdata_fix = 32'h0;
    for (int m = 0; m < 2; m++) preq[m] = '0;
    do_reset(1'b1);

    // Inst read with fixed slave latencies.
    addr_wait = 1; data_wait = 1; rdata_fix_en = 1'b1; rdata_fix = 32'h3C08_BFC0;
    issue(0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0);
    tick(); chk("rd_c0_sreq", sn_sreq, 0);
    tick(); chk("rd_c1", {sn_sreq, sn_saddr, sn_iaok}, {1'b1, 32'hBFC0_0000, 1'b0});
    tick(); chk("rd_c2", {sn_sreq, sn_iaok, sn_daok}, {1'b1, 1'b1, 1'b0});
    tick(); chk("rd_c3", {sn_sreq, sn_busy, sn_idok}, {1'b0, 1'b1, 1'b0});
    tick(); chk("rd_c4", {sn_idok, sn_irdata, sn_ddok}, {1'b1, 32'h3C08_BFC0, 1'b0});
    tick(); chk("rd_c5_busy", sn_busy, 0);
    rdata_fix_en = 1'b0; addr_wait = 0; data_wait = 0;

    // Simultaneous requests straight after reset: data first.
    do_reset(1'b0);
    obs.delete();
    issue(0, 1'b0, 2'd2, 32'hBFC0_0004, 32'h0);
    issue(1, 1'b0, 2'd2, 32'h8000_1000, 32'h0);
    tick(); tick();
    chk("sim_first_addr", {sn_sreq, sn_saddr}, {1'b1, 32'h8000_1000});
    wait_idle("sim_drain");
    check_order("sim_order", 6'b000001, 2);

    // Persistent contention alternates.
    do_reset(1'b0);
    obs.delete();
    addr_wait = -1; data_wait = -1; reissue_left = 4;
    issue(0, 1'b0, 2'd2, $urandom, 32'h0);
    issue(1, 1'b0, 2'd2, $urandom, 32'h0);
    wait_idle("rr_drain");
    check_order("rr_order", 6'b010101, 6);

    // Data byte write.
    addr_wait = 1;
    issue(1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB);
    tick(); tick();
    chk("wr_fwd", {sn_sreq, sn_swr, sn_ssize, sn_saddr, sn_swdata},
        {1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB});
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (sn_ddok) found = 1'b1;
    end
    chk("wr_data_ok", found, 1);
    wait_idle("wr_drain");

    // Reset while in DATA abandons the transaction.
    addr_wait = 0; data_wait = 5;
    issue(0, 1'b0, 2'd2, 32'h8000_2000, 32'h0);
    tick(); tick();
    resetn = 1'b0;
    #1;
    chk("rst_data_busy_sreq", {busy, s_req}, 0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    force_dok = 1'b1;
    tick();
    force_dok = 1'b0;
    chk("rst_stray_dok", sn_idok, 0);
    obs.delete();
    data_wait = 1;
    issue(0, 1'b0, 2'd2, 32'hBFC0_0010, 32'h0);
    wait_idle("rst_next_drain");
    chk("rst_next_served", obs.size(), 1);

    // Abandoned request: owner drops req before s_addr_ok.
    addr_wait = 5;
    issue(1, 1'b0, 2'd2, 32'h8000_4000, 32'h0);
    tick(); tick();
    chk("ab_c1_sreq", sn_sreq, 1);
    pend[1] = 1'b0;
    tick();
    chk("ab_c2", {sn_sreq, sn_daok, sn_ddok}, 0);
    tick();
    chk("ab_c3_busy", sn_busy, 0);
    obs.delete();
    addr_wait = -1; data_wait = -1;
    issue(0, 1'b0, 2'd2, 32'hBFC0_0020, 32'h0);
    issue(1, 1'b0, 2'd2, 32'h8000_5000, 32'h0);
    wait_idle("ab_drain");
    check_order("ab_order", 6'b000010, 2);

    // Randomized traffic with stray slave handshakes.
    stray_en = 1'b1; auto_en = 1'b1;
    repeat (3000) tick();
    auto_en = 1'b0;
    wait_idle("rand_drain");
    stray_en = 1'b0;
    tick();
    chk("grant_q_empty", gq.size(), 0);
    chk("rdata_q_empty", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
